// File: rtl/stopwatch_up.sv
// Count-up BCD stopwatch, 0:00 to D2_LIMIT:59, with start/pause, clear and lap freeze.
// Runs in the control clock domain; tick is a one-cycle 1 Hz enable.
module stopwatch_up #(
    parameter int LED_W    = 16,
    parameter int D2_LIMIT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tick,
    input  logic             start_pulse,
    input  logic             lap_pulse,
    input  logic             clear_pulse,
    output logic [3:0]       digit2,
    output logic [3:0]       digit1,
    output logic [3:0]       digit0,
    output logic             running,
    output logic             lap_active,
    output logic [LED_W-1:0] led
);

    localparam logic [3:0] D2_MAX = 4'(D2_LIMIT);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        PAUSE,
        DONE
    } state_t;

    state_t      state;
    logic [3:0]  cnt2;
    logic [3:0]  cnt1;
    logic [3:0]  cnt0;
    logic [11:0] snap;
    logic        lap_hold;

    logic [3:0]  nx2;
    logic [3:0]  nx1;
    logic [3:0]  nx0;
    logic        nx_full;
    logic        inc_full;

    // BCD increment with carry through the 9 and 5 digit limits
    always_comb begin
        nx2 = cnt2;
        nx1 = cnt1;
        nx0 = cnt0;
        if (cnt0 == 4'd9) begin
            nx0 = 4'd0;
            if (cnt1 == 4'd5) begin
                nx1 = 4'd0;
                nx2 = cnt2 + 4'd1;
            end else begin
                nx1 = cnt1 + 4'd1;
            end
        end else begin
            nx0 = cnt0 + 4'd1;
        end
        nx_full  = (nx2 == D2_MAX) && (nx1 == 4'd5) && (nx0 == 4'd9);
        inc_full = tick && nx_full;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt2     <= 4'd0;
            cnt1     <= 4'd0;
            cnt0     <= 4'd0;
            snap     <= 12'd0;
            lap_hold <= 1'b0;
            running  <= 1'b0;
            led      <= '0;
        end else if (clear_pulse) begin
            state    <= IDLE;
            cnt2     <= 4'd0;
            cnt1     <= 4'd0;
            cnt0     <= 4'd0;
            lap_hold <= 1'b0;
            running  <= 1'b0;
            led      <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start_pulse) begin
                        state   <= RUN;
                        running <= 1'b1;
                    end
                end
                RUN: begin
                    if (tick) begin
                        cnt2 <= nx2;
                        cnt1 <= nx1;
                        cnt0 <= nx0;
                    end
                    if (lap_pulse && !lap_hold) begin
                        snap     <= {cnt2, cnt1, cnt0};
                        lap_hold <= 1'b1;
                    end else if (lap_pulse) begin
                        lap_hold <= 1'b0;
                    end
                    // Full scale overrides both a coincident pause and lap
                    if (inc_full) begin
                        state    <= DONE;
                        running  <= 1'b0;
                        led      <= '1;
                        lap_hold <= 1'b0;
                    end else if (start_pulse) begin
                        state   <= PAUSE;
                        running <= 1'b0;
                    end
                end
                PAUSE: begin
                    if (lap_pulse && lap_hold) begin
                        lap_hold <= 1'b0;
                    end
                    if (start_pulse) begin
                        state   <= RUN;
                        running <= 1'b1;
                    end
                end
                DONE: begin
                    state <= DONE;
                end
            endcase
        end
    end

    assign digit2     = lap_hold ? snap[11:8] : cnt2;
    assign digit1     = lap_hold ? snap[7:4]  : cnt1;
    assign digit0     = lap_hold ? snap[3:0]  : cnt0;
    assign lap_active = lap_hold;

endmodule

// File: tb/tb_stopwatch_up.sv
// Scoreboard bench for stopwatch_up: seconds-based model, queued expectations,
// independent monitor comparing every cycle.
module tb_stopwatch_up;

    localparam int LED_W    = 16;
    localparam int D2_LIMIT = 1;
    localparam int FULL     = D2_LIMIT * 60 + 59;
    localparam int EW       = 12 + 2 + LED_W;

    logic             clk;
    logic             rst_n;
    logic             tick;
    logic             start_pulse;
    logic             lap_pulse;
    logic             clear_pulse;
    logic [3:0]       digit2;
    logic [3:0]       digit1;
    logic [3:0]       digit0;
    logic             running;
    logic             lap_active;
    logic [LED_W-1:0] led;

    stopwatch_up #(.LED_W(LED_W), .D2_LIMIT(D2_LIMIT)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .tick(tick),
        .start_pulse(start_pulse),
        .lap_pulse(lap_pulse),
        .clear_pulse(clear_pulse),
        .digit2(digit2),
        .digit1(digit1),
        .digit0(digit0),
        .running(running),
        .lap_active(lap_active),
        .led(led)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    logic [EW-1:0] exp_q[$];

    // Model: elapsed seconds as an integer; mode 0 idle, 1 run, 2 pause, 3 done
    int m_sec  = 0;
    int m_mode = 0;
    int m_hold = 0;
    int m_snap = 0;

    function automatic logic [11:0] to_bcd(input int s);
        logic [11:0] r;
        r[11:8] = 4'(s / 60);
        r[7:4]  = 4'((s % 60) / 10);
        r[3:0]  = 4'(s % 10);
        return r;
    endfunction

    function automatic logic [EW-1:0] model_out();
        logic [LED_W-1:0] l;
        l = (m_mode == 3) ? {LED_W{1'b1}} : {LED_W{1'b0}};
        return {to_bcd(m_hold != 0 ? m_snap : m_sec),
                1'(m_mode == 1), 1'(m_hold != 0), l};
    endfunction

    task automatic model_step(input bit t, input bit s, input bit l, input bit c);
        int nsec;
        if (c) begin
            m_mode = 0;
            m_sec  = 0;
            m_hold = 0;
        end else if (m_mode == 1) begin
            nsec = t ? m_sec + 1 : m_sec;
            if (l) begin
                if (m_hold == 0) begin
                    m_snap = m_sec;
                    m_hold = 1;
                end else begin
                    m_hold = 0;
                end
            end
            if (nsec == FULL) begin
                m_mode = 3;
                m_hold = 0;
            end else if (s) begin
                m_mode = 2;
            end
            m_sec = nsec;
        end else if (m_mode == 0) begin
            if (s) m_mode = 1;
        end else if (m_mode == 2) begin
            if (l && m_hold != 0) m_hold = 0;
            if (s) m_mode = 1;
        end
    endtask

    task automatic step(input bit t, input bit s, input bit l, input bit c);
        @(negedge clk);
        tick        = t;
        start_pulse = s;
        lap_pulse   = l;
        clear_pulse = c;
        model_step(t, s, l, c);
        exp_q.push_back(model_out());
        @(posedge clk);
    endtask

    task automatic ticks(input int n);
        repeat (n) step(1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic idle_in();
        tick        = 1'b0;
        start_pulse = 1'b0;
        lap_pulse   = 1'b0;
        clear_pulse = 1'b0;
    endtask

    // Monitor: outputs are settled 2 time units after each rising edge
    always @(posedge clk) begin
        logic [EW-1:0] e;
        logic [EW-1:0] a;
        #2;
        cyc++;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = {digit2, digit1, digit0, running, lap_active, led};
            checks++;
            if (a !== e) begin
                failures++;
                $display("FAIL cycle%0d outputs got d=%h run=%b lap=%b led=%h exp d=%h run=%b lap=%b led=%h",
                         cyc, a[EW-1:EW-12], a[LED_W+1], a[LED_W], a[LED_W-1:0],
                         e[EW-1:EW-12], e[LED_W+1], e[LED_W], e[LED_W-1:0]);
            end
        end
    end

    task automatic check_async_zero();
        logic [EW-1:0] a;
        a = {digit2, digit1, digit0, running, lap_active, led};
        checks++;
        if (a !== '0) begin
            failures++;
            $display("FAIL async_reset got %h exp 0", a);
        end
    endtask

    initial begin
        int r;
        bit t;
        bit s;
        bit l;
        bit c;
        rst_n = 1'b0;
        idle_in();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        step(0, 1, 0, 0);
        ticks(75);

        step(0, 0, 0, 1);
        step(0, 1, 0, 0);
        ticks(59);
        ticks(1);
        ticks(59);
        ticks(3);
        step(0, 1, 0, 0);
        step(0, 0, 1, 0);
        step(0, 0, 0, 1);
        step(0, 0, 0, 0);

        step(0, 1, 0, 0);
        ticks(12);
        step(0, 1, 0, 0);
        ticks(5);
        step(0, 1, 0, 0);
        ticks(3);
        step(0, 0, 0, 1);

        step(0, 1, 0, 0);
        ticks(20);
        step(0, 0, 1, 0);
        ticks(10);
        step(0, 0, 1, 0);
        step(0, 0, 0, 1);

        step(0, 1, 0, 0);
        ticks(8);
        step(1, 1, 0, 0);
        ticks(2);
        step(0, 0, 0, 1);
        step(0, 1, 0, 0);
        ticks(30);
        step(1, 0, 0, 1);
        step(0, 1, 0, 0);
        ticks(40);
        step(1, 0, 1, 0);
        step(0, 0, 0, 0);
        step(0, 1, 0, 0);
        step(0, 0, 1, 0);
        step(0, 0, 0, 1);

        // Asynchronous reset mid-count at 1:07
        step(0, 1, 0, 0);
        ticks(67);
        @(negedge clk);
        idle_in();
        #2;
        rst_n = 1'b0;
        #1;
        check_async_zero();
        m_sec  = 0;
        m_mode = 0;
        m_hold = 0;
        m_snap = 0;
        @(negedge clk);
        rst_n = 1'b1;
        ticks(10);

        for (int i = 0; i < 3000; i++) begin
            r = int'($urandom_range(0, 999));
            t = (r % 2) == 0;
            s = $urandom_range(0, 99) < 4;
            l = $urandom_range(0, 99) < 5;
            c = $urandom_range(0, 999) < 4;
            step(t, s, l, c);
        end

        @(negedge clk);
        idle_in();
        for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(negedge clk);
        if (exp_q.size() > 0) begin
            failures++;
            $display("FAIL drain pending=%0d exp 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
